// File: rtl/ysyx_22050854_mul_booth_switch.sv
// Radix-4 Booth partial-product generator and column transposer for the 64x64 multiplier front end.
// Optional zero-operand shortcut enabled by YSYX_22050854_MUL_ZERO_BYPASS_EN (IDLE -> HOLD with all-zero columns).
module ysyx_22050854_mul_booth_switch #(
    parameter int XLEN = 64
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     flush,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [XLEN-1:0]                          src1,
    input  logic [XLEN-1:0]                          src2,
    input  logic [1:0]                               mul_signed,
    input  logic [1:0]                               op_tag,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [((XLEN+2)/2)*(2*(XLEN+2))-1:0]     col_bits,
    output logic [1:0]                               out_tag
);
    localparam int BW   = XLEN + 2;
    localparam int NPP  = BW / 2;
    localparam int NCOL = 2 * BW;

    typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

    state_t                state_q;
    logic [XLEN-1:0]       src1_q, src2_q;
    logic [1:0]            sgn_q, tag_q;
    logic [NPP*NCOL-1:0]   col_q, col_d;
    logic [1:0]            out_tag_q;

    logic [BW-1:0]         x_ext, y_ext;
    logic [NCOL-1:0]       x_wide;
    logic [BW:0]           y_grp;
    logic [NCOL-1:0]       pp [NPP];

    assign x_ext  = {{2{sgn_q[1] & src1_q[XLEN-1]}}, src1_q};
    assign y_ext  = {{2{sgn_q[0] & src2_q[XLEN-1]}}, src2_q};
    assign x_wide = {{BW{x_ext[BW-1]}}, x_ext};
    // Appending a zero below Y supplies the Y[-1] bit of group 0.
    assign y_grp  = {y_ext, 1'b0};

    always_comb begin
        logic [NCOL-1:0] val;
        for (int j = 0; j < NPP; j++) begin
            val = '0;
            case (y_grp[2*j +: 3])
                3'b001, 3'b010: val = x_wide;
                3'b011:         val = x_wide << 1;
                3'b100:         val = -(x_wide << 1);
                3'b101, 3'b110: val = -x_wide;
                default:        val = '0;
            endcase
            pp[j] = val << (2*j);
        end
    end

    always_comb begin
        col_d = '0;
        for (int i = 0; i < NCOL; i++) begin
            for (int j = 0; j < NPP; j++) begin
                col_d[NPP*i + j] = pp[j][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src1_q    <= '0;
            src2_q    <= '0;
            sgn_q     <= '0;
            tag_q     <= '0;
            col_q     <= '0;
            out_tag_q <= '0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src1_q <= src1;
                        src2_q <= src2;
                        sgn_q  <= mul_signed;
                        tag_q  <= op_tag;
`ifdef YSYX_22050854_MUL_ZERO_BYPASS_EN
                        if (src1 == '0 || src2 == '0) begin
                            state_q   <= HOLD;
                            col_q     <= '0;
                            out_tag_q <= op_tag;
                        end else begin
                            state_q <= GEN;
                        end
`else
                        state_q <= GEN;
`endif
                    end
                end
                GEN: begin
                    col_q     <= col_d;
                    out_tag_q <= tag_q;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign col_bits  = col_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ysyx_22050854_mul_booth_switch.sv
// Scoreboard bench: expected products are queued at acceptance and compared against the column-weighted sum when out_valid handshakes.
module tb_ysyx_22050854_mul_booth_switch;
    localparam int NPP  = 33;
    localparam int NCOL = 132;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [63:0]      src1, src2;
    logic [1:0]       mul_signed, op_tag, out_tag;
    logic [4355:0]    col_bits;

    typedef struct {
        logic [127:0] prod;
        logic [1:0]   tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22050854_mul_booth_switch #(.XLEN(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .mul_signed(mul_signed), .op_tag(op_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .col_bits(col_bits), .out_tag(out_tag)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg);
        logic [127:0] ea, eb;
        ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
        eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
        return ea * eb;
    endfunction

    function automatic logic [127:0] colsum(input logic [4355:0] cb);
        logic [131:0] s;
        logic [131:0] cnt;
        s = '0;
        for (int i = 0; i < NCOL; i++) begin
            cnt = 132'($countones(cb[NPP*i +: NPP]));
            s   = s + (cnt << i);
        end
        return s[127:0];
    endfunction

    function automatic int lat_for(input logic [63:0] a, input logic [63:0] b);
`ifdef YSYX_22050854_MUL_ZERO_BYPASS_EN
        if (a == 64'd0 || b == 64'd0) return 1;
`endif
        return 2;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg, input logic [1:0] tg);
        chk("pre_rdy", in_ready, 1);
        src1 = a; src2 = b; mul_signed = sg; op_tag = tg; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        src1 = '1; src2 = '1; mul_signed = ~sg; op_tag = ~tg;
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                          input logic [1:0] tg, input int hold, output logic [127:0] res);
        exp_t e;
        int lat, exp_lat;
        logic [4355:0] snap;
        exp_lat = lat_for(a, b);
        out_ready = 1'b0;
        accept(a, b, sg, tg);
        e.prod = model(a, b, sg);
        e.tag  = tg;
        sb.push_back(e);
        lat = 1;
        if (exp_lat == 2) chk("gen_rdy", in_ready, 0);
        while (!out_valid && lat < 8) begin
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        snap = col_bits;
        for (int k = 0; k < hold; k++) begin
            chk("bp_vld", out_valid, 1);
            chk("bp_rdy", in_ready, 0);
            chk("bp_col", col_bits == snap, 1);
            step();
        end
        out_ready = 1'b1;
        e = sb.pop_front();
        res = colsum(col_bits);
        chk("prod", res, e.prod);
        chk("tag", out_tag, e.tag);
        step();
        out_ready = 1'b0;
        chk("post_rdy", in_ready, 1);
        chk("post_vld", out_valid, 0);
    endtask

    initial begin
        logic [127:0] r;
        logic [63:0]  a, b;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; mul_signed = '0; op_tag = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_col", |col_bits, 0);
        chk("rst_tag", out_tag, 0);

        run_op(64'd3, 64'd5, 2'b00, 2'b01, 0, r);
        chk("3x5", r, 128'd15);
        run_op('1, '1, 2'b11, 2'b10, 0, r);
        chk("m1xm1", r, 128'd1);
        run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 2'b11, 0, r);
        chk("m2xmax", r, {64'hFFFF_FFFF_FFFF_FFFE, 64'h2});
        run_op(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, 2'b01, 2'b00, 5, r);
        run_op(64'd0, 64'h1234, 2'b00, 2'b10, 0, r);
        chk("zero_col", |col_bits, 0);

        for (int n = 0; n < 10; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            run_op(a, b, 2'($urandom_range(3)), 2'($urandom_range(3)), $urandom_range(2), r);
        end

        accept(64'd7, 64'd9, 2'b00, 2'b01);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_rdy", in_ready, 1);
        chk("fl_vld", out_valid, 0);
        step();
        chk("fl_vld2", out_valid, 0);

        flush = 1'b1; in_valid = 1'b1; src1 = 64'd2; src2 = 64'd2;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_noacc", in_ready, 1);
        step();
        chk("fl_noacc_vld", out_valid, 0);

        accept(64'd11, 64'd13, 2'b00, 2'b11);
        step();
        chk("rh_vld", out_valid, 1);
        chk("rh_col", colsum(col_bits), 128'd143);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rh_vld0", out_valid, 0);
        chk("rh_col0", |col_bits, 0);
        chk("rh_tag0", out_tag, 0);
        chk("rh_rdy", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
